// File: rtl/calc_sequencer_if.sv
// Keypad, arithmetic-engine and display signals of the calculator sequencer.
// The sequencer connects through the slave modport; the keypad/engine side through the master modport.
interface calc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             op_valid;
  logic [2:0]       op_sel;
  logic             neg_valid;
  logic             equal_valid;
  logic             clear_valid;
  logic             op_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_code;
  logic             op_done;
  logic [WIDTH-1:0] op_result;
  logic             op_overflow;
  logic [WIDTH-1:0] display_output;
  logic             complete;
  logic             error;
  logic             busy;

  modport master (
    output digit_valid, digit, op_valid, op_sel, neg_valid, equal_valid, clear_valid,
    output op_done, op_result, op_overflow,
    input  op_start, op_a, op_b, op_code, display_output, complete, error, busy
  );

  modport slave (
    input  digit_valid, digit, op_valid, op_sel, neg_valid, equal_valid, clear_valid,
    input  op_done, op_result, op_overflow,
    output op_start, op_a, op_b, op_code, display_output, complete, error, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-to-arithmetic sequencer: builds signed operands from digit strobes, dispatches
// operations to an external engine over start/done, and presents results for display.
module calc_sequencer #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input logic             clk,
  input logic             nRST,
  calc_sequencer_if.slave bus
);
  localparam logic [2:0] ENTER_A = 3'd0;
  localparam logic [2:0] ENTER_B = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] RESULT  = 3'd4;
  localparam logic [2:0] ERROR   = 3'd5;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Largest typeable magnitude is 2^(WIDTH-1)-1, so the most negative value only arises as a result.
  localparam logic [WIDTH+3:0] MAG_LIMIT = {5'b0, {(WIDTH-1){1'b1}}};

  logic [2:0]       state;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, hold_reg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_a, neg_b, b_touched, abort;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic [2:0]       op_reg, pending_op;

  logic             ev_clear, ev_equal, ev_op, ev_neg, ev_digit;
  logic             op_ok, digit_ok, busy_now, do_clear;
  logic [WIDTH-1:0] cur_mag, new_mag, new_val, disp_now;
  logic [CW-1:0]    cur_cnt;
  logic             cur_neg;
  logic [WIDTH+3:0] mag_ext, new_mag_w;

  // One keypad event per cycle, highest priority wins.
  assign ev_clear = bus.clear_valid;
  assign ev_equal = bus.equal_valid & ~ev_clear;
  assign ev_op    = bus.op_valid & ~bus.equal_valid & ~ev_clear;
  assign ev_neg   = bus.neg_valid & ~bus.op_valid & ~bus.equal_valid & ~ev_clear;
  assign ev_digit = bus.digit_valid & ~bus.neg_valid & ~bus.op_valid & ~bus.equal_valid & ~ev_clear;
  assign op_ok    = (bus.op_sel == 3'b001) || (bus.op_sel == 3'b010) || (bus.op_sel == 3'b100);
  assign busy_now = (state == EXEC) || (state == WAIT);
  assign do_clear = (ev_clear && !busy_now) ||
                    (state == WAIT && bus.op_done && (abort || ev_clear));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_mag = mag_a;
    cur_cnt = cnt_a;
    cur_neg = neg_a;
    if (state == ENTER_B) begin
      cur_mag = mag_b;
      cur_cnt = cnt_b;
      cur_neg = neg_b;
    end else if (state == RESULT) begin
      cur_mag = '0;
      cur_cnt = '0;
      cur_neg = 1'b0;
    end
  end

  assign mag_ext   = {4'b0, cur_mag};
  assign new_mag_w = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, bus.digit};
  assign new_mag   = new_mag_w[WIDTH-1:0];
  assign new_val   = cur_neg ? -new_mag : new_mag;
  assign digit_ok  = (bus.digit <= 4'd9) && (cur_cnt != CW'(MAX_DIGITS)) && (new_mag_w <= MAG_LIMIT);

  always_comb begin
    disp_now = '0;
    case (state)
      ENTER_A:    disp_now = a_reg;
      ENTER_B:    disp_now = b_touched ? b_reg : a_reg;
      EXEC, WAIT: disp_now = hold_reg;
      RESULT:     disp_now = result_reg;
      default:    disp_now = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; async reset clears every register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= ENTER_A;
      a_reg <= '0; b_reg <= '0; result_reg <= '0; hold_reg <= '0;
      mag_a <= '0; mag_b <= '0; neg_a <= 1'b0; neg_b <= 1'b0;
      cnt_a <= '0; cnt_b <= '0; b_touched <= 1'b0; abort <= 1'b0;
      op_reg <= '0; pending_op <= '0;
    end else if (do_clear) begin
      state <= ENTER_A;
      a_reg <= '0; b_reg <= '0; result_reg <= '0; hold_reg <= '0;
      mag_a <= '0; mag_b <= '0; neg_a <= 1'b0; neg_b <= 1'b0;
      cnt_a <= '0; cnt_b <= '0; b_touched <= 1'b0; abort <= 1'b0;
      op_reg <= '0; pending_op <= '0;
    end else begin
      case (state)
        ENTER_A: begin
          if (ev_op && op_ok) begin
            op_reg <= bus.op_sel;
            mag_b <= '0; neg_b <= 1'b0; cnt_b <= '0; b_reg <= '0; b_touched <= 1'b0;
            state <= ENTER_B;
          end else if (ev_neg) begin
            neg_a <= ~neg_a;
            a_reg <= -a_reg;
          end else if (ev_digit && digit_ok) begin
            mag_a <= new_mag;
            cnt_a <= cnt_a + CW'(1);
            a_reg <= new_val;
          end
        end
        ENTER_B: begin
          if (ev_equal) begin
            if (cnt_b == '0) b_reg <= a_reg;
            hold_reg <= disp_now;
            state    <= EXEC;
          end else if (ev_op && op_ok) begin
            if (cnt_b == '0) begin
              op_reg <= bus.op_sel;
            end else begin
              pending_op <= bus.op_sel;
              hold_reg   <= disp_now;
              state      <= EXEC;
            end
          end else if (ev_neg) begin
            neg_b     <= ~neg_b;
            b_reg     <= -b_reg;
            b_touched <= 1'b1;
          end else if (ev_digit && digit_ok) begin
            mag_b     <= new_mag;
            cnt_b     <= cnt_b + CW'(1);
            b_reg     <= new_val;
            b_touched <= 1'b1;
          end
        end
        EXEC: begin
          if (ev_clear) abort <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (ev_clear) abort <= 1'b1;
          if (bus.op_done) begin
            if (bus.op_overflow) begin
              state <= ERROR;
            end else if (pending_op != '0) begin
              a_reg      <= bus.op_result;
              op_reg     <= pending_op;
              pending_op <= '0;
              mag_b <= '0; neg_b <= 1'b0; cnt_b <= '0; b_reg <= '0; b_touched <= 1'b0;
              state <= ENTER_B;
            end else begin
              result_reg <= bus.op_result;
              state      <= RESULT;
            end
          end
        end
        RESULT: begin
          if (ev_equal) begin
            a_reg    <= result_reg;
            hold_reg <= result_reg;
            state    <= EXEC;
          end else if (ev_op && op_ok) begin
            a_reg  <= result_reg;
            op_reg <= bus.op_sel;
            mag_b <= '0; neg_b <= 1'b0; cnt_b <= '0; b_reg <= '0; b_touched <= 1'b0;
            state <= ENTER_B;
          end else if (ev_digit && digit_ok) begin
            mag_a <= new_mag;
            cnt_a <= CW'(1);
            neg_a <= 1'b0;
            a_reg <= new_val;
            state <= ENTER_A;
          end
        end
        ERROR:   ;
        default: state <= ENTER_A;
      endcase
    end
  end

  assign bus.op_start       = (state == EXEC);
  assign bus.op_a           = a_reg;
  assign bus.op_b           = b_reg;
  assign bus.op_code        = op_reg;
  assign bus.display_output = disp_now;
  assign bus.complete       = (state == RESULT);
  assign bus.error          = (state == ERROR);
  assign bus.busy           = busy_now;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer: keypad sequences with a scripted engine
// whose results and overflow flags are hand-computed.
module tb_calc_sequencer;
  localparam int WIDTH = 16;
  localparam int K_DIG = 0, K_OP = 1, K_NEG = 2, K_EQ = 3, K_CLR = 4;

  logic clk = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  calc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  calc_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(5)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.digit_valid = 1'b0; bus.op_valid = 1'b0; bus.neg_valid = 1'b0;
    bus.equal_valid = 1'b0; bus.clear_valid = 1'b0;
  endtask

  // One-cycle key strobe; returns at the negedge where the accepted event is visible.
  task automatic press(input int kind, input logic [3:0] val);
    @(negedge clk);
    case (kind)
      K_DIG: begin bus.digit_valid = 1'b1; bus.digit = val; end
      K_OP:  begin bus.op_valid = 1'b1; bus.op_sel = val[2:0]; end
      K_NEG: bus.neg_valid = 1'b1;
      K_EQ:  bus.equal_valid = 1'b1;
      default: bus.clear_valid = 1'b1;
    endcase
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic engine_done(input int delay, input logic [WIDTH-1:0] res, input logic ovf);
    repeat (delay) @(negedge clk);
    bus.op_done = 1'b1; bus.op_result = res; bus.op_overflow = ovf;
    @(negedge clk);
    bus.op_done = 1'b0; bus.op_overflow = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.digit = '0; bus.op_sel = '0;
    bus.op_done = 1'b0; bus.op_result = '0; bus.op_overflow = 1'b0;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    check("rst_display", bus.display_output, 0);
    check("rst_op_start", bus.op_start, 0);
    check("rst_op_a", bus.op_a, 0);
    check("rst_op_b", bus.op_b, 0);
    check("rst_op_code", bus.op_code, 0);
    check("rst_flags", {bus.complete, bus.error, bus.busy}, 0);

    // 1,2,3 then neg then equal: equal in ENTER_A is ignored
    press(K_DIG, 1); press(K_DIG, 2); press(K_DIG, 3);
    check("t1_disp_123", bus.display_output, 123);
    press(K_NEG, 0);
    check("t1_disp_neg", bus.display_output, 16'hFF85);
    press(K_EQ, 0);
    check("t1_eq_no_start", bus.op_start, 0);
    check("t1_eq_not_busy", bus.busy, 0);
    check("t1_disp_keep", bus.display_output, 16'hFF85);

    // 12 + 34 = 46, then repeat-equals 46 + 34 = 80
    press(K_CLR, 0);
    press(K_DIG, 1); press(K_DIG, 2); press(K_OP, 4'b0001);
    check("t2_disp_a_kept", bus.display_output, 12);
    press(K_DIG, 3); press(K_DIG, 4);
    check("t2_disp_b", bus.display_output, 34);
    press(K_EQ, 0);
    check("t2_start", bus.op_start, 1);
    check("t2_op_a", bus.op_a, 12);
    check("t2_op_b", bus.op_b, 34);
    check("t2_op_code", bus.op_code, 3'b001);
    @(negedge clk);
    check("t2_start_one_cycle", bus.op_start, 0);
    check("t2_busy", bus.busy, 1);
    check("t2_no_complete_busy", bus.complete, 0);
    engine_done(1, 46, 1'b0);
    check("t2_complete", bus.complete, 1);
    check("t2_disp_46", bus.display_output, 46);
    check("t2_idle", bus.busy, 0);
    press(K_EQ, 0);
    check("t2_rep_start", bus.op_start, 1);
    check("t2_rep_complete_drop", bus.complete, 0);
    check("t2_rep_op_a", bus.op_a, 46);
    check("t2_rep_op_b", bus.op_b, 34);
    engine_done(2, 80, 1'b0);
    check("t2_disp_80", bus.display_output, 80);
    check("t2_rep_complete", bus.complete, 1);

    // 7 * 6 - 2 = 40 with operator chaining
    press(K_CLR, 0);
    press(K_DIG, 7); press(K_OP, 4'b0100); press(K_DIG, 6); press(K_OP, 4'b0010);
    check("t3_start1", bus.op_start, 1);
    check("t3_code1", bus.op_code, 3'b100);
    check("t3_a1", bus.op_a, 7);
    check("t3_b1", bus.op_b, 6);
    engine_done(2, 42, 1'b0);
    check("t3_chain_disp", bus.display_output, 42);
    check("t3_chain_complete", bus.complete, 0);
    check("t3_chain_idle", bus.busy, 0);
    press(K_DIG, 2);
    check("t3_disp_b", bus.display_output, 2);
    press(K_EQ, 0);
    check("t3_start2", bus.op_start, 1);
    check("t3_code2", bus.op_code, 3'b010);
    check("t3_a2", bus.op_a, 42);
    check("t3_b2", bus.op_b, 2);
    engine_done(1, 40, 1'b0);
    check("t3_disp_40", bus.display_output, 40);
    check("t3_complete", bus.complete, 1);

    // Magnitude limit and digit-count limit
    press(K_CLR, 0);
    press(K_DIG, 3); press(K_DIG, 2); press(K_DIG, 7); press(K_DIG, 6); press(K_DIG, 8);
    check("t4_mag_limit", bus.display_output, 3276);
    press(K_CLR, 0);
    for (int d = 1; d <= 6; d++) press(K_DIG, 4'(d));
    check("t4_digit_limit", bus.display_output, 12345);
    press(K_NEG, 0);
    check("t4_neg_12345", bus.display_output, 16'hCFC7);

    // Overflow -> ERROR, everything but clear ignored
    press(K_CLR, 0);
    press(K_DIG, 2); press(K_DIG, 0); press(K_DIG, 0); press(K_OP, 4'b0100);
    press(K_DIG, 2); press(K_DIG, 0); press(K_DIG, 0); press(K_EQ, 0);
    check("t5_start", bus.op_start, 1);
    check("t5_code", bus.op_code, 3'b100);
    engine_done(2, 16'h9C40, 1'b1);
    check("t5_error", bus.error, 1);
    check("t5_disp_zero", bus.display_output, 0);
    check("t5_not_complete", bus.complete, 0);
    press(K_DIG, 5); press(K_OP, 4'b0001); press(K_EQ, 0);
    check("t5_err_no_start", bus.op_start, 0);
    check("t5_err_held", bus.error, 1);
    check("t5_err_disp", bus.display_output, 0);
    press(K_CLR, 0);
    check("t5_clr_error", bus.error, 0);
    check("t5_clr_disp", bus.display_output, 0);

    // Priority: op beats a same-cycle digit; equal with no B digits uses B = A
    press(K_DIG, 5);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_sel = 3'b010; bus.digit_valid = 1'b1; bus.digit = 4'd9;
    @(negedge clk);
    idle_inputs();
    check("t6_prio_disp", bus.display_output, 5);
    press(K_EQ, 0);
    check("t6_b_eq_a_start", bus.op_start, 1);
    check("t6_b_eq_a_opb", bus.op_b, 5);
    check("t6_b_eq_a_code", bus.op_code, 3'b010);
    engine_done(1, 0, 1'b0);
    check("t6_result_zero", bus.display_output, 0);
    check("t6_complete", bus.complete, 1);

    // Clear-with-abort: 5 + = then clear during WAIT; overflow on the aborted result is ignored
    press(K_CLR, 0);
    press(K_DIG, 5); press(K_OP, 4'b0001); press(K_EQ, 0);
    check("t7_start", bus.op_start, 1);
    check("t7_op_a", bus.op_a, 5);
    check("t7_op_b", bus.op_b, 5);
    press(K_CLR, 0);
    check("t7_busy_after_clr", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_busy_hold", bus.busy, 1);
      check("t7_no_complete", bus.complete, 0);
    end
    engine_done(0, 10, 1'b1);
    check("t7_idle", bus.busy, 0);
    check("t7_no_error", bus.error, 0);
    check("t7_complete_low", bus.complete, 0);
    check("t7_disp_zero", bus.display_output, 0);
    check("t7_regs_cleared", bus.op_a, 0);
    press(K_DIG, 4);
    check("t7_enter_a", bus.display_output, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Parametrised keypad-to-arithmetic sequencer for the signed calculator. It accumulates signed decimal operands from single-digit key strobes and latches the operator. It dispatches each operation to an external add/sub/mult engine over a start/done handshake and presents the result for display. It adds the following over the current controller:
- configurable width and digit limit
- sign entry
- operator chaining and repeat-equals
- overflow/error state
- clear-with-abort

Parameters:
WIDTH, 16, operand/result width, two's complement (min 8)
MAX_DIGITS, 5, maximum decimal digits accepted per operand

Ports:
clk  in  1  clock
nRST  in  1  reset, asynchronous, active-low
digit_valid  in  1  one-cycle strobe: digit present
digit  in  4  BCD digit; codes >9 ignored
op_valid  in  1  one-cycle strobe: operator present
op_sel  in  3  one-hot: 001 add, 010 sub, 100 mul; other codes ignored
neg_valid  in  1  toggle sign of operand being entered
equal_valid  in  1  execute
clear_valid  in  1  clear all
op_start  out  1  one-cycle request to arithmetic engine
op_a  out  WIDTH  operand A, signed
op_b  out  WIDTH  operand B, signed
op_code  out  3  one-hot operator, same encoding as op_sel
op_done  in  1  engine finished; op_result/op_overflow valid this cycle
op_result  in  WIDTH  signed result
op_overflow  in  1  result not representable
display_output  out  WIDTH  signed value for display
complete  out  1  high while a valid result is displayed
error  out  1  high in ERROR
busy  out  1  high in EXEC/WAIT

Behaviour:
- Reset state, all outputs and registers:
  - state ENTER_A
  - all outputs 0; operands, sign flags, digit counts, stored op and abort flag 0
- Input priority, one event per cycle: clear > equal > op > neg > digit. Lower-priority strobes in the same cycle are dropped.
- States: ENTER_A, ENTER_B, EXEC, WAIT, RESULT, ERROR.
- Digit entry (ENTER_A/ENTER_B, or RESULT which first clears A then enters ENTER_A):
  - new magnitude = mag*10 + digit, computed as (mag<<3)+(mag<<1)+digit in WIDTH+4 bits
  - rejected, with no state change, if count==MAX_DIGITS or new magnitude > 2^(WIDTH-1)-1
  - leading zeros count as digits
- neg toggles the sign of the current entry. Entry value = sign ? -mag : mag.
- display_output:
  - ENTER_A: entry A; ENTER_B: entry B (A until the first B digit or neg)
  - RESULT: last result; ERROR: 0
  - updated the cycle after the accepted event
- ENTER_A:
  - op → store op, go ENTER_B with B cleared
  - equal → ignored
- ENTER_B:
  - op with no B digits → replace stored op
  - op with ≥1 B digit → execute A op B; pending_op = new op
  - equal with no B digits → B = A, then execute
  - equal with digits → execute
- EXEC (exactly 1 cycle):
  - op_start = 1; op_a/op_b/op_code driven from registers
  - op_a/op_b/op_code held stable until op_done
  - op_start is asserted the cycle after the accepting edge of equal/op
  - next state WAIT
- WAIT:
  - op_done sampled only here; done coincident with op_start is impossible by construction
  - on op_done with op_overflow=1 → ERROR
  - else, if pending_op set → A = op_result, op = pending_op, B cleared, go ENTER_B; display shows result, complete stays 0
  - else → RESULT: display = op_result, complete = 1
- RESULT:
  - op → A = result, B cleared, ENTER_B
  - equal → repeat: A = result, B and op unchanged, EXEC
  - digit → new entry in ENTER_A
  - complete drops the cycle the state leaves RESULT
- ERROR: error = 1; everything except clear ignored.
- Clear:
  - in any state other than EXEC/WAIT → ENTER_A, all registers reset values next cycle
  - in EXEC/WAIT → set abort; stay busy until op_done, discard result (overflow ignored), then ENTER_A cleared
- Sign-magnitude limit: the most negative value (-2^(WIDTH-1)) cannot be typed; it can appear only as a result.

Test Plan:
- Digits 1,2,3 then neg, then equal → display 123, then 0xFF85 (-123); equal causes no op_start.
- 1,2,+,3,4,= with engine done 3 cycles after start, result 46 → op_start high exactly 1 cycle (cycle after equal), op_a=12, op_b=34, op_code=001; then complete=1, display=46; second = → op_a=46, op_b=34, result 80.
- 7,*,6,- then 2,= → first op_start op_code=100 (a=7, b=6); result 42; ENTER_B with display 42, complete 0; second op_start op_code=010, a=42, b=2; display 40, complete=1.
- Digits 3,2,7,6,8 → fifth rejected, display 3276; 1,2,3,4,5,6 (5-digit limit) → display 12345.
- 200*200= with engine op_overflow=1 → error=1, display 0; digits/op/equal ignored; clear → error=0, ENTER_A, display 0.
- 5,+,=, then clear during WAIT, op_done 5 cycles later → busy stays 1 until done; complete never rises; then busy=0, display 0, state ENTER_A.
